mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multicycle control unit for the next-generation MIPS core; replaces the single-cycle control decode.
- A state machine sequences fetch/decode/execute/memory/writeback over several cycles so one memory port and one ALU can be shared.
- Adds a req/ready memory handshake with a parametrised timeout, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register and the datapath muxes, register file, ALU control and PC register.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles per memory access; 0 disables the timeout.
- CNT_WIDTH, 32: width of the retired-instruction counter.
- WAIT_WIDTH, 8: width of the wait counter; must satisfy MEM_TIMEOUT < 2^WAIT_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction bits [31:26] from the IR.
- funct  input  6  instruction bits [5:0] from the IR.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  request is a write; valid only with mem_req.
- iord  output  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load the IR.
- pc_write  output  1  PC enable; branch condition already folded in.
- pc_source  output  2  next-PC select: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  output  2  ALU B select: 0 = rt, 1 = 4, 2 = signext, 3 = signext<<2.
- alu_op  output  3  to ALUControl: 000 add, 001 sub, 010 funct, 011 or, 100 and, 101 lui.
- reg_dst  output  2  write-register select: 0 = rt, 1 = rd, 2 = 31.
- mem_to_reg  output  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC.
- reg_write  output  1  register file write enable.
- fault  output  1  sticky fault flag.
- instr_retired  output  CNT_WIDTH  retired-instruction count.
- state_dbg  output  4  current state encoding.

Behaviour:
- Reset: asynchronous, active-high, fixed polarity.
  - While reset is high: state = IDLE, every control output 0, fault 0, instr_retired 0, wait counter 0.
- Control outputs are Moore, decoded from state. Exceptions: ir_write and pc_write are qualified by mem_ready in FETCH, and pc_write by zero in BRANCH.
- IDLE: all outputs 0. Goes to FETCH unconditionally on the next cycle.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_source=0.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1 and pc_write=1 (PC+4), then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut). Dispatches on opcode:
  - 0x23 or 0x2B -> MEM_ADDR.
  - 0x00 with funct 0x08 -> JR.
  - 0x00 with any other funct -> R_EXEC.
  - 0x08, 0x0C, 0x0D or 0x0F -> I_EXEC.
  - 0x04 or 0x05 -> BRANCH.
  - 0x02 -> JUMP.
  - 0x03 -> JAL.
  - Any other opcode -> FAULT.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_req=1, iord=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retires.
- MEM_WRITE: mem_req=1, mem_write=1, iord=1. Holds until mem_ready, then retires.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=010. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retires.
- I_EXEC: alu_src_a=1, alu_src_b=2. alu_op is add (0x08), and (0x0C), or (0x0D), lui (0x0F). Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retires.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=sub, pc_source=1.
  - pc_write = zero for beq, ~zero for bne.
  - Retires.
- JUMP: pc_source=2, pc_write=1. Retires.
- JAL: pc_source=2, pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2 (PC, already incremented to PC+4). Retires.
- JR: pc_source=3, pc_write=1. Retires.
- Retire: next state is FETCH and instr_retired increments by 1, wrapping modulo 2^CNT_WIDTH.
- Wait counter:
  - Clears on entry to any mem_req state and whenever mem_ready=1.
  - Increments on each cycle with mem_req=1 and mem_ready=0.
  - With MEM_TIMEOUT != 0: when the count reaches MEM_TIMEOUT with mem_ready still 0, the next state is FAULT.
  - mem_ready arriving in the same cycle the count hits the limit wins: the access completes, no fault.
- FAULT: all control outputs 0, fault=1. Exits only on reset.
- Reset asserted mid-access: mem_req drops asynchronously. No partial write enables are generated.

Decomposition:
- Package mips_mc_pkg holds:
  - the state encoding: IDLE=0, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, FAULT=15;
  - the opcode and funct constants;
  - the alu_op, pc_source, reg_dst and mem_to_reg encodings.
- One sub-module, mips_mc_wait_timer: wait counter plus timeout compare.
  - Inputs: clk, reset, start, busy, done.
  - Output: expired.

Test Plan:
- add (opcode 0, funct 0x20), mem_ready=1 -> states FETCH, DECODE, R_EXEC, R_WB, FETCH; reg_write=1 only in R_WB; instr_retired goes 0->1.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_READ -> mem_req held 4 cycles per access; ir_write a single pulse; reg_write pulse with mem_to_reg=1; no fault.
- beq with zero=1, then bne with zero=1 -> pc_write=1 with pc_source=1 for beq; pc_write=0 for bne.
- jal (0x03) -> a single cycle with pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2. jr (0/0x08) -> pc_source=3.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 wait cycles; fault stays 1; a reset pulse returns to IDLE, then FETCH.
- Opcode 0x3F -> DECODE then FAULT. Separately, a reset pulse mid MEM_WRITE -> mem_req and mem_write drop immediately, instr_retired = 0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the state encoding, opcode/funct constants, the datapath select
// encodings and a helper that decodes the state-dependent control word.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StRExec    = 4'd7,
        StRWb      = 4'd8,
        StIExec    = 4'd9,
        StIWb      = 4'd10,
        StBranch   = 4'd11,
        StJump     = 4'd12,
        StJal      = 4'd13,
        StJr       = 4'd14,
        StFault    = 4'd15
    } state_e;

    // Opcodes (instruction bits [31:26]) and funct codes (bits [5:0]).
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FunctJr = 6'h08;

    // ALUControl operation select.
    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluFunct = 3'b010;
    localparam logic [2:0] AluOr    = 3'b011;
    localparam logic [2:0] AluAnd   = 3'b100;
    localparam logic [2:0] AluLui   = 3'b101;

    // Next-PC select.
    localparam logic [1:0] PcAlu    = 2'd0;
    localparam logic [1:0] PcAluOut = 2'd1;
    localparam logic [1:0] PcJump   = 2'd2;
    localparam logic [1:0] PcRs     = 2'd3;

    // ALU B operand select.
    localparam logic [1:0] SrcBRt      = 2'd0;
    localparam logic [1:0] SrcBFour    = 2'd1;
    localparam logic [1:0] SrcBImm     = 2'd2;
    localparam logic [1:0] SrcBImmSh2  = 2'd3;

    // Write-register select.
    localparam logic [1:0] DstRt = 2'd0;
    localparam logic [1:0] DstRd = 2'd1;
    localparam logic [1:0] DstRa = 2'd2;

    // Write-data select.
    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMdr = 2'd1;
    localparam logic [1:0] WbPc  = 2'd2;

    // Registered control word. fetch_en, br_eq and br_ne are not outputs
    // themselves: they mark where ir_write/pc_write must be qualified by
    // mem_ready or zero in the same cycle.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       fetch_en;
        logic       pc_write;
        logic       br_eq;
        logic       br_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // Moore control word for a state; opcode selects the I-type ALU op and
    // the branch sense.
    function automatic ctrl_t ctrl_decode(state_e st, logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.mem_req   = 1'b1;
                c.fetch_en  = 1'b1;
                c.alu_src_b = SrcBFour;
            end
            StDecode: c.alu_src_b = SrcBImmSh2;
            StMemAddr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SrcBImm;
            end
            StMemRead: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WbMdr;
            end
            StMemWrite: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            StRExec: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = AluFunct;
            end
            StRWb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = DstRd;
            end
            StIExec: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SrcBImm;
                case (opcode)
                    OpAndi:  c.alu_op = AluAnd;
                    OpOri:   c.alu_op = AluOr;
                    OpLui:   c.alu_op = AluLui;
                    default: c.alu_op = AluAdd;
                endcase
            end
            StIWb: c.reg_write = 1'b1;
            StBranch: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = AluSub;
                c.pc_source = PcAluOut;
                c.br_eq     = (opcode == OpBeq);
                c.br_ne     = (opcode == OpBne);
            end
            StJump: begin
                c.pc_source = PcJump;
                c.pc_write  = 1'b1;
            end
            StJal: begin
                c.pc_source  = PcJump;
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.reg_dst    = DstRa;
                c.mem_to_reg = WbPc;
            end
            StJr: begin
                c.pc_source = PcRs;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_wait_timer.sv
// Memory wait counter with timeout compare.
//   clk, reset : clock and asynchronous active-high reset
//   start      : clear the count (entering a memory-request state)
//   busy       : a memory request is outstanding this cycle
//   done       : memory completes the access this cycle
//   expired    : count has reached MEM_TIMEOUT and memory is still not ready
module mips_mc_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned WAIT_WIDTH  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    input  logic done,
    output logic expired
);

    logic [WAIT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (start || done) begin
            count_d = '0;
        end else if (busy) begin
            count_d = count_q + WAIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // done in the same cycle as the limit wins, so it masks expiry.
    assign expired = (MEM_TIMEOUT != 0) && busy && !done
                     && (count_q == WAIT_WIDTH'(MEM_TIMEOUT));

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit.
// Sequences fetch/decode/execute/memory/writeback so one memory port and one
// ALU are shared, with a req/ready memory handshake, access timeout, illegal
// opcode trapping and a retired-instruction counter.
//   Inputs : clk, reset, opcode/funct from the IR, ALU zero, mem_ready.
//   Outputs: memory request (mem_req, mem_write, iord), IR/PC enables,
//            datapath selects (pc_source, alu_src_a/b, alu_op, reg_dst,
//            mem_to_reg), reg_write, sticky fault, instr_retired, state_dbg.
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned WAIT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_source,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_op,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 reg_write,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] instr_retired,
    output logic [3:0]           state_dbg
);

    state_e                state_q, state_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic                  fault_q, fault_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;
    logic                  retire;
    logic                  timer_start;
    logic                  expired;

    mips_mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .WAIT_WIDTH  (WAIT_WIDTH)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (timer_start),
        .busy    (ctrl_q.mem_req),
        .done    (mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (expired) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                case (opcode)
                    OpLw, OpSw:                     state_d = StMemAddr;
                    OpRtype:                        state_d = (funct == FunctJr) ? StJr : StRExec;
                    OpAddi, OpAndi, OpOri, OpLui:   state_d = StIExec;
                    OpBeq, OpBne:                   state_d = StBranch;
                    OpJ:                            state_d = StJump;
                    OpJal:                          state_d = StJal;
                    default:                        state_d = StFault;
                endcase
            end
            StMemAddr: state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (expired) begin
                    state_d = StFault;
                end
            end
            StMemWrite: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (expired) begin
                    state_d = StFault;
                end
            end
            StRExec: state_d = StRWb;
            StIExec: state_d = StIWb;
            StMemWb, StRWb, StIWb, StBranch, StJump, StJal, StJr: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase

        fault_d     = (state_d == StFault);
        // Control word for the coming state, registered so it is glitch-free
        // and cleared asynchronously by reset.
        ctrl_d      = ctrl_decode(state_d, opcode);
        retired_d   = retired_q + CNT_WIDTH'(retire);
        timer_start = (state_d != state_q)
                      && (state_d inside {StFetch, StMemRead, StMemWrite});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ctrl_q    <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign mem_req       = ctrl_q.mem_req;
    assign mem_write     = ctrl_q.mem_write;
    assign iord          = ctrl_q.iord;
    assign ir_write      = ctrl_q.fetch_en & mem_ready;
    assign pc_write      = ctrl_q.pc_write
                           | (ctrl_q.fetch_en & mem_ready)
                           | (ctrl_q.br_eq & zero)
                           | (ctrl_q.br_ne & ~zero);
    assign pc_source     = ctrl_q.pc_source;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write     = ctrl_q.reg_write;
    assign fault         = fault_q;
    assign instr_retired = retired_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: the stimulus process walks each instruction through the
// state sequence the architecture prescribes, pushing the expected outputs of
// every cycle; a monitor pops and compares on each falling edge.
module tb_mips_multicycle_control;

    localparam int TMO = 4;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                   S_MEM_READ = 4, S_MEM_WB = 5, S_MEM_WRITE = 6, S_R_EXEC = 7,
                   S_R_WB = 8, S_I_EXEC = 9, S_I_WB = 10, S_BRANCH = 11,
                   S_JUMP = 12, S_JAL = 13, S_JR = 14, S_FAULT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;
    logic        mem_req, mem_write, iord, ir_write, pc_write;
    logic [1:0]  pc_source, alu_src_b, reg_dst, mem_to_reg;
    logic        alu_src_a, reg_write, fault;
    logic [2:0]  alu_op;
    logic [31:0] instr_retired;
    logic [3:0]  state_dbg;

    mips_multicycle_control #(
        .MEM_TIMEOUT (TMO),
        .CNT_WIDTH   (32),
        .WAIT_WIDTH  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .fault         (fault),
        .instr_retired (instr_retired),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic        mem_req, mem_write, iord, ir_write, pc_write;
        logic [1:0]  pc_source;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [2:0]  alu_op;
        logic [1:0]  reg_dst, mem_to_reg;
        logic        reg_write, fault;
        logic [31:0] retired;
    } obs_t;

    obs_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_retired = 32'd0;
    logic [5:0]  cur_op = 6'd0;
    logic [5:0]  cur_fn = 6'd0;

    function automatic obs_t sample();
        obs_t o;
        o.st = state_dbg;         o.mem_req = mem_req;     o.mem_write = mem_write;
        o.iord = iord;            o.ir_write = ir_write;   o.pc_write = pc_write;
        o.pc_source = pc_source;  o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
        o.alu_op = alu_op;        o.reg_dst = reg_dst;     o.mem_to_reg = mem_to_reg;
        o.reg_write = reg_write;  o.fault = fault;         o.retired = instr_retired;
        return o;
    endfunction

    // Output table of each state as the architecture defines it.
    function automatic obs_t base(int st);
        obs_t e;
        e = '0;
        e.st = 4'(st);
        e.retired = exp_retired;
        case (st)
            S_FETCH:     begin e.mem_req = 1; e.alu_src_b = 2'd1; end
            S_DECODE:    e.alu_src_b = 2'd3;
            S_MEM_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
            S_MEM_READ:  begin e.mem_req = 1; e.iord = 1; end
            S_MEM_WB:    begin e.reg_write = 1; e.mem_to_reg = 2'd1; end
            S_MEM_WRITE: begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; end
            S_R_EXEC:    begin e.alu_src_a = 1; e.alu_op = 3'b010; end
            S_R_WB:      begin e.reg_write = 1; e.reg_dst = 2'd1; end
            S_I_EXEC:    begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
            S_I_WB:      e.reg_write = 1;
            S_BRANCH:    begin e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_source = 2'd1; end
            S_JUMP:      begin e.pc_source = 2'd2; e.pc_write = 1; end
            S_JAL:       begin
                e.pc_source = 2'd2; e.pc_write = 1; e.reg_write = 1;
                e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
            end
            S_JR:        begin e.pc_source = 2'd3; e.pc_write = 1; end
            S_FAULT:     e.fault = 1;
            default:     ;
        endcase
        return e;
    endfunction

    // One cycle: drive inputs, push the expected outputs, advance to the next
    // cycle (always entered and left at posedge+1).
    task automatic cyc(input obs_t e, input logic rdy, input logic z, input bit garble);
        mem_ready = rdy;
        zero = z;
        if (garble) begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
        end else begin
            opcode = cur_op;
            funct  = cur_fn;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rcyc(input int st);
        cyc(base(st), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic retire_cyc(input int st);
        rcyc(st);
        exp_retired = exp_retired + 32'd1;
    endtask

    task automatic fault_hold();
        for (int k = 0; k < 3; k++) cyc(base(S_FAULT), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    // Memory access with w not-ready cycles; beyond TMO waits it faults.
    task automatic mem_access(input int st, input int w, output bit faulted);
        obs_t e;
        int   n;
        bit   g;
        g = (st == S_FETCH);
        n = (w > TMO) ? TMO + 1 : w;
        for (int k = 0; k < n; k++) cyc(base(st), 1'b0, 1'($urandom), g);
        faulted = (w > TMO);
        if (!faulted) begin
            e = base(st);
            if (st == S_FETCH) begin
                e.ir_write = 1;
                e.pc_write = 1;
            end
            cyc(e, 1'b1, 1'($urandom), g);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        bit   f;
        obs_t e;
        mem_access(S_FETCH, fw, f);
        if (f) begin fault_hold(); return; end
        cur_op = op;
        cur_fn = fn;
        rcyc(S_DECODE);
        case (op)
            6'h23: begin
                rcyc(S_MEM_ADDR);
                mem_access(S_MEM_READ, mw, f);
                if (f) fault_hold(); else retire_cyc(S_MEM_WB);
            end
            6'h2B: begin
                rcyc(S_MEM_ADDR);
                mem_access(S_MEM_WRITE, mw, f);
                if (f) fault_hold(); else exp_retired = exp_retired + 32'd1;
            end
            6'h00: begin
                if (fn == 6'h08) retire_cyc(S_JR);
                else begin rcyc(S_R_EXEC); retire_cyc(S_R_WB); end
            end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                e = base(S_I_EXEC);
                e.alu_op = (op == 6'h0C) ? 3'b100 : (op == 6'h0D) ? 3'b011 :
                           (op == 6'h0F) ? 3'b101 : 3'b000;
                cyc(e, 1'($urandom), 1'($urandom), 1'b0);
                retire_cyc(S_I_WB);
            end
            6'h04, 6'h05: begin
                e = base(S_BRANCH);
                e.pc_write = (op == 6'h04) ? z : ~z;
                cyc(e, 1'($urandom), z, 1'b0);
                exp_retired = exp_retired + 32'd1;
            end
            6'h02: retire_cyc(S_JUMP);
            6'h03: retire_cyc(S_JAL);
            default: fault_hold();
        endcase
    endtask

    task automatic check_zero(input string name);
        obs_t got;
        got = sample();
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL %s: outputs got=%h want=0", name, got);
        end
    endtask

    // Starts and ends at posedge+1; leaves the DUT in its IDLE cycle.
    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        check_zero(name);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_retired = 32'd0;
        rcyc(S_IDLE);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        obs_t got, e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = sample();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL cycle t=%0t state got=%0d want=%0d outputs got=%h want=%h",
                         $time, got.st, e.st, got, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [12];
        logic [5:0] op, fn;
        obs_t       got;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F,
                6'h04, 6'h05, 6'h02, 6'h03};
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
        @(posedge clk);
        #1;
        do_reset("reset_initial");

        run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add
        run_instr(6'h23, 6'h00, 1'b0, 3, 3);   // lw, slow memory
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // bne not taken
        run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // jal
        run_instr(6'h00, 6'h08, 1'b0, 0, 0);   // jr
        run_instr(6'h23, 6'h00, 1'b0, TMO, TMO); // ready exactly at the limit
        run_instr(6'h2B, 6'h00, 1'b0, 1, TMO);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 11)];
            fn = 6'($urandom);
            if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08;
            run_instr(op, fn, 1'($urandom), $urandom_range(0, TMO), $urandom_range(0, TMO));
        end

        run_instr(6'h00, 6'h20, 1'b0, TMO + 2, 0);   // fetch timeout
        do_reset("reset_after_timeout");
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);         // illegal opcode
        do_reset("reset_after_illegal");
        run_instr(6'h23, 6'h00, 1'b0, 0, TMO + 5);   // read timeout
        do_reset("reset_after_read_timeout");
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);

        // sw stalled in MEM_WRITE, then reset between clock edges
        begin
            bit f;
            mem_access(S_FETCH, 0, f);
            cur_op = 6'h2B;
            cur_fn = 6'h00;
            rcyc(S_DECODE);
            rcyc(S_MEM_ADDR);
            cyc(base(S_MEM_WRITE), 1'b0, 1'b0, 1'b0);
            cyc(base(S_MEM_WRITE), 1'b0, 1'b0, 1'b0);
            #1;
            got = sample();
            total++;
            if (!(got.mem_req === 1'b1 && got.mem_write === 1'b1 && got.retired === 32'd1)) begin
                bad++;
                $display("FAIL pre_reset_write: req/write/retired got=%b%b/%0d want=11/1",
                         got.mem_req, got.mem_write, got.retired);
            end
            do_reset("reset_mid_write");
        end
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
